// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-side memory responder.
// Bus size codes, load size encoding and the responder FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        LS_NONE = 2'd0,
        LS_BYTE = 2'd1,
        LS_HALF = 2'd2,
        LS_WORD = 2'd3
    } LoadSize_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } MemState_t;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
    localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

    function automatic logic wen_legal(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Loads size from LoadSize; stores from the byte-enable pattern.
    function automatic logic [1:0] bus_size(input logic [3:0] wen,
                                            input logic [1:0] lsize);
        if (wen == 4'b0000) begin
            if (lsize == LS_NONE)
                return BUS_SIZE_WORD;
            return lsize - 2'd1;
        end
        case (wen)
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: return BUS_SIZE_BYTE;
            4'b0011, 4'b1100: return BUS_SIZE_HALF;
            default:          return BUS_SIZE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0]  size,
                                              input logic [31:0] wdata);
        case (size)
            BUS_SIZE_BYTE: return {4{wdata[7:0]}};
            BUS_SIZE_HALF: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_responder_if.sv
// SRAM-like data bus between the responder (master) and memory (slave).
interface mem_data_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Lane select and sign/zero extension of a raw 32-bit read word.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_lsize,
    input  logic        i_sign,
    input  logic        i_load,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = '0;
        if (i_load) begin
            case (i_lsize)
                LS_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
                LS_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
                default: o_data = i_rdata;
            endcase
        end
    end
endmodule

// File: rtl/mem_data_responder.sv
// Turns one EXE memory request into a single data-bus transaction,
// stalling the pipeline until it completes and returning load data.
module mem_data_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EXE_Req,
    input  logic [3:0]           EXE_Wen,
    input  logic [ADDR_W-1:0]    EXE_Addr,
    input  logic [DATA_W-1:0]    EXE_WData,
    input  logic [1:0]           EXE_LoadSize,
    input  logic                 EXE_LoadSign,
    input  logic                 MEM_Flush,
    mem_data_responder_if.master bus,
    output logic                 MEM_Stall,
    output logic                 MEM_RValid,
    output logic [DATA_W-1:0]    MEM_RData
);
    MemState_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic [1:0]        r_lsize;
    logic              r_lsign;
    logic              r_kill;
    logic              r_stale;
    logic [DATA_W-1:0] r_rdata;

    logic              w_accept;
    logic              w_kill;
    logic [1:0]        w_size;
    logic [DATA_W-1:0] w_ext;

    assign w_accept = (r_state == IDLE) & EXE_Req & ~MEM_Flush;
    assign w_kill   = MEM_Flush | r_kill;
    assign w_size   = bus_size(EXE_Wen, EXE_LoadSize);

    mem_load_align u_align (
        .i_rdata   (bus.data_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_lsize   (r_lsize),
        .i_sign    (r_lsign),
        .i_load    (r_wen == 4'b0000),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_lsize <= '0;
            r_lsign <= 1'b0;
            r_kill  <= 1'b0;
            r_rdata <= '0;
            // A reply may still be on its way; remember that a late one is legal.
            r_stale <= (r_state == REQ) | (r_state == WAIT) |
                       (r_state == DRAIN);
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.data_data_ok)
                        r_stale <= 1'b0;
                    if (w_accept) begin
                        r_addr  <= EXE_Addr;
                        r_wen   <= EXE_Wen;
                        r_wdata <= wdata_rep(w_size, EXE_WData);
                        r_size  <= w_size;
                        r_lsize <= EXE_LoadSize;
                        r_lsign <= EXE_LoadSign;
                        r_kill  <= 1'b0;
                        r_stale <= 1'b0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.data_addr_ok) begin
                        if (w_kill)
                            r_state <= bus.data_data_ok ? IDLE : DRAIN;
                        else if (bus.data_data_ok) begin
                            r_rdata <= w_ext;
                            r_state <= DONE;
                        end else
                            r_state <= WAIT;
                    end else if (MEM_Flush)
                        r_kill <= 1'b1;
                end
                WAIT: begin
                    if (MEM_Flush)
                        r_state <= bus.data_data_ok ? IDLE : DRAIN;
                    else if (bus.data_data_ok) begin
                        r_rdata <= w_ext;
                        r_state <= DONE;
                    end
                end
                DONE:  r_state <= IDLE;
                DRAIN: if (bus.data_data_ok) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data_req   = (r_state == REQ);
    assign bus.data_wr    = |r_wen;
    assign bus.data_size  = r_size;
    assign bus.data_addr  = r_addr;
    assign bus.data_wdata = r_wdata;

    assign MEM_Stall  = w_accept | (r_state == REQ) |
                        (r_state == WAIT) | (r_state == DRAIN);
    assign MEM_RValid = (r_state == DONE) & ~MEM_Flush;
    assign MEM_RData  = r_rdata;

    a_wen_legal: assert property (@(posedge clk) disable iff (rst)
        (w_accept && EXE_Wen != 4'b0000) |-> wen_legal(EXE_Wen));

    a_early_data_ok: assert property (@(posedge clk) disable iff (rst)
        (r_state == REQ && !bus.data_addr_ok) |-> !bus.data_data_ok);

    a_idle_data_ok: assert property (@(posedge clk) disable iff (rst)
        (r_state == IDLE && bus.data_data_ok) |-> r_stale);
endmodule

// File: tb/tb_mem_data_responder.sv
// Directed bench with a scoreboard queue checked by a separate RValid monitor.
module tb_mem_data_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_Req;
    logic [3:0]  EXE_Wen;
    logic [31:0] EXE_Addr;
    logic [31:0] EXE_WData;
    logic [1:0]  EXE_LoadSize;
    logic        EXE_LoadSign;
    logic        MEM_Flush;
    logic        MEM_Stall;
    logic        MEM_RValid;
    logic [31:0] MEM_RData;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    mem_data_responder_if bus ();

    mem_data_responder dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_Req      (EXE_Req),
        .EXE_Wen      (EXE_Wen),
        .EXE_Addr     (EXE_Addr),
        .EXE_WData    (EXE_WData),
        .EXE_LoadSize (EXE_LoadSize),
        .EXE_LoadSign (EXE_LoadSign),
        .MEM_Flush    (MEM_Flush),
        .bus          (bus),
        .MEM_Stall    (MEM_Stall),
        .MEM_RValid   (MEM_RValid),
        .MEM_RData    (MEM_RData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && MEM_RValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: got RData %h expected no RValid",
                         MEM_RData);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (MEM_RData !== e) begin
                    errors++;
                    $display("FAIL rdata: got %h expected %h", MEM_RData, e);
                end
            end
        end
    end

    // Runs one full transaction starting in an IDLE cycle; ends in IDLE.
    task automatic do_op(input string nm, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] lsz, input logic sgn,
                         input logic [31:0] rd, input logic [31:0] exp,
                         input logic [1:0] esz, input logic [31:0] ewd,
                         input int dly);
        EXE_Req      = 1'b1;
        EXE_Wen      = wen;
        EXE_Addr     = addr;
        EXE_WData    = wd;
        EXE_LoadSize = lsz;
        EXE_LoadSign = sgn;
        exp_q.push_back(exp);
        #1 chk({nm, "_stall_accept"}, 32'(MEM_Stall), 32'd1);
        for (int i = 0; i <= dly; i++) begin
            cyc();
            EXE_Req = 1'b0;
            EXE_Addr = 32'h0;
            EXE_WData = 32'h0;
            bus.data_addr_ok = (i == dly);
            #1;
            chk({nm, "_req"},   32'(bus.data_req),  32'd1);
            chk({nm, "_addr"},  bus.data_addr,      addr);
            chk({nm, "_wdata"}, bus.data_wdata,     ewd);
            chk({nm, "_size"},  32'(bus.data_size), 32'(esz));
            chk({nm, "_wr"},    32'(bus.data_wr),   32'(wen != 4'b0000));
            chk({nm, "_stall_req"}, 32'(MEM_Stall), 32'd1);
        end
        cyc();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rd;
        #1 chk({nm, "_stall_wait"}, 32'(MEM_Stall), 32'd1);
        cyc();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        #1;
        chk({nm, "_rvalid"},     32'(MEM_RValid), 32'd1);
        chk({nm, "_stall_done"}, 32'(MEM_Stall),  32'd0);
        cyc();
        #1 chk({nm, "_rvalid_pulse"}, 32'(MEM_RValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        EXE_Req = 1'b0;
        EXE_Wen = 4'h0;
        EXE_Addr = 32'h0;
        EXE_WData = 32'h0;
        EXE_LoadSize = 2'd0;
        EXE_LoadSign = 1'b0;
        MEM_Flush = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'h0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_req",    32'(bus.data_req), 32'd0);
        chk("rst_rvalid", 32'(MEM_RValid),   32'd0);
        chk("rst_rdata",  MEM_RData,         32'd0);
        chk("rst_stall",  32'(MEM_Stall),    32'd0);
        cyc();

        do_op("lw",  4'b0000, 32'h8000_0010, 32'h0, 2'd3, 1'b0,
              32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd2, 32'h0, 0);
        do_op("lb",  4'b0000, 32'h8000_0013, 32'h0, 2'd1, 1'b1,
              32'h8011_2233, 32'hFFFF_FF80, 2'd0, 32'h0, 0);
        do_op("lhu", 4'b0000, 32'h8000_0012, 32'h0, 2'd2, 1'b0,
              32'h8011_2233, 32'h0000_8011, 2'd1, 32'h0, 0);
        do_op("lh",  4'b0000, 32'h8000_0016, 32'h0, 2'd2, 1'b1,
              32'h9ABC_1234, 32'hFFFF_9ABC, 2'd1, 32'h0, 0);
        do_op("lbu", 4'b0000, 32'h8000_0011, 32'h0, 2'd1, 1'b0,
              32'h1122_8344, 32'h0000_0083, 2'd0, 32'h0, 0);
        do_op("sh",  4'b1100, 32'h8000_0022, 32'h0000_ABCD, 2'd0, 1'b0,
              32'h1234_5678, 32'h0, 2'd1, 32'hABCD_ABCD, 0);
        do_op("sb",  4'b0010, 32'h8000_0021, 32'h0000_005A, 2'd0, 1'b0,
              32'h1234_5678, 32'h0, 2'd0, 32'h5A5A_5A5A, 5);
        do_op("sw",  4'b1111, 32'h8000_0030, 32'hCAFE_F00D, 2'd0, 1'b0,
              32'h0, 32'h0, 2'd2, 32'hCAFE_F00D, 0);

        // Flush while waiting for data: reply is drained, no completion.
        EXE_Req = 1'b1;
        EXE_Wen = 4'b0000;
        EXE_Addr = 32'h8000_0050;
        EXE_LoadSize = 2'd3;
        cyc();
        EXE_Req = 1'b0;
        bus.data_addr_ok = 1'b1;
        cyc();
        bus.data_addr_ok = 1'b0;
        MEM_Flush = 1'b1;
        #1 chk("fl_stall_wait", 32'(MEM_Stall), 32'd1);
        cyc();
        MEM_Flush = 1'b0;
        #1;
        chk("fl_stall_drain", 32'(MEM_Stall),  32'd1);
        chk("fl_rvalid",      32'(MEM_RValid), 32'd0);
        cyc();
        #1 chk("fl_stall_drain2", 32'(MEM_Stall), 32'd1);
        cyc();
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h7777_7777;
        #1 chk("fl_stall_dok", 32'(MEM_Stall), 32'd1);
        cyc();
        bus.data_data_ok = 1'b0;
        #1 chk("fl_rvalid_after", 32'(MEM_RValid), 32'd0);
        do_op("lw2", 4'b0000, 32'h8000_0040, 32'h0, 2'd3, 1'b0,
              32'h0BAD_C0DE, 32'h0BAD_C0DE, 2'd2, 32'h0, 0);

        // Reset in WAIT, then a stray data_ok in IDLE.
        EXE_Req = 1'b1;
        EXE_Addr = 32'h8000_0060;
        cyc();
        EXE_Req = 1'b0;
        bus.data_addr_ok = 1'b1;
        cyc();
        bus.data_addr_ok = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_req",    32'(bus.data_req), 32'd0);
        chk("mrst_rvalid", 32'(MEM_RValid),   32'd0);
        chk("mrst_rdata",  MEM_RData,         32'd0);
        chk("mrst_stall",  32'(MEM_Stall),    32'd0);
        chk("mrst_addr",   bus.data_addr,     32'd0);
        cyc();
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h5555_5555;
        #1 chk("stray_stall", 32'(MEM_Stall), 32'd0);
        cyc();
        bus.data_data_ok = 1'b0;
        #1;
        chk("stray_rvalid", 32'(MEM_RValid), 32'd0);
        chk("stray_req",    32'(bus.data_req), 32'd0);
        repeat (2) cyc();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
